// File: rtl/traffic_lights_xing.sv
// Multi-direction traffic light controller: round-robin service of
// NUM_DIRS signal heads with all-red clearance and ms-based phase timing.
module traffic_lights_xing #(
    parameter int NUM_DIRS              = 4,
    parameter int CLK_PER_MS            = 2,
    parameter int BLINK_HALF_PERIOD_MS  = 10,
    parameter int BLINK_GREEN_TIME_TICK = 2,
    parameter int RED_YELLOW_MS         = 5,
    parameter int DEFAULT_GREEN_MS      = 10,
    parameter int DEFAULT_YELLOW_MS     = 10,
    parameter int DEFAULT_CLEAR_MS      = 2,
    localparam int DIR_W = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [2:0]          cmd_type_i,
    input  logic [DIR_W-1:0]    cmd_dir_i,
    input  logic                cmd_valid_i,
    input  logic [15:0]         cmd_data_i,
    output logic [NUM_DIRS-1:0] red_o,
    output logic [NUM_DIRS-1:0] yellow_o,
    output logic [NUM_DIRS-1:0] green_o,
    output logic [DIR_W-1:0]    active_dir_o
);

    typedef enum logic [2:0] {
        S_CLEAR, S_RY, S_G, S_GB, S_Y, S_NOTR, S_OFF
    } state_e;

    localparam logic [2:0] CMD_ON     = 3'd0;
    localparam logic [2:0] CMD_OFF    = 3'd1;
    localparam logic [2:0] CMD_NOTR   = 3'd2;
    localparam logic [2:0] CMD_GREEN  = 3'd3;
    localparam logic [2:0] CMD_CLEAR  = 3'd4;
    localparam logic [2:0] CMD_YELLOW = 3'd5;

    localparam logic [15:0] PRESC_MAX = 16'(CLK_PER_MS - 1);
    localparam logic [15:0] HP_MAX    = 16'(BLINK_HALF_PERIOD_MS - 1);
    localparam logic [15:0] RY_MS     = 16'(RED_YELLOW_MS);
    localparam logic [15:0] GB_MS     =
        16'(2 * BLINK_GREEN_TIME_TICK * BLINK_HALF_PERIOD_MS);

    state_e              state_q, state_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [15:0]         presc_q, presc_d;
    logic [15:0]         ms_q, ms_d;
    logic [15:0]         hp_q, hp_d;
    logic                blink_q, blink_d;
    logic [15:0]         green_q  [NUM_DIRS];
    logic [15:0]         green_d  [NUM_DIRS];
    logic [15:0]         yellow_q [NUM_DIRS];
    logic [15:0]         yellow_d [NUM_DIRS];
    logic [15:0]         clear_q, clear_d;

    logic                ms_tick, done, cmd_hit;
    logic [15:0]         period, eff;
    logic [NUM_DIRS-1:0] act;

    assign ms_tick      = (presc_q == PRESC_MAX);
    assign active_dir_o = dir_q;

    always_comb begin
        period = 16'd1;
        case (state_q)
            S_CLEAR: period = clear_q;
            S_RY:    period = RY_MS;
            S_G:     period = green_q[dir_q];
            S_GB:    period = GB_MS;
            S_Y:     period = yellow_q[dir_q];
            default: period = 16'd1;
        endcase
        eff  = (period == 16'd0) ? 16'd1 : period;
        done = ms_tick && (ms_q == eff - 16'd1);
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cmd_hit = 1'b0;
        if (cmd_valid_i) begin
            unique case (1'b1)
                cmd_type_i == CMD_OFF: begin
                    state_d = S_OFF;
                    cmd_hit = 1'b1;
                end
                cmd_type_i == CMD_NOTR && state_q != S_OFF: begin
                    state_d = S_NOTR;
                    cmd_hit = 1'b1;
                end
                cmd_type_i == CMD_ON &&
                (state_q == S_OFF || state_q == S_NOTR): begin
                    state_d = S_CLEAR;
                    dir_d   = '0;
                    cmd_hit = 1'b1;
                end
                default: ;
            endcase
        end
        // An accepted command overrides a phase expiring in the same cycle
        if (!cmd_hit && done) begin
            case (state_q)
                S_CLEAR: state_d = S_RY;
                S_RY:    state_d = S_G;
                S_G:     state_d = S_GB;
                S_GB:    state_d = S_Y;
                S_Y: begin
                    state_d = S_CLEAR;
                    dir_d   = (dir_q == DIR_W'(NUM_DIRS - 1)) ?
                              '0 : dir_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        hp_d    = hp_q;
        blink_d = blink_q;
        if (state_d != state_q || state_q == S_OFF) begin
            presc_d = '0;
            ms_d    = '0;
            hp_d    = '0;
            blink_d = 1'b1;
        end else if (ms_tick) begin
            presc_d = '0;
            ms_d    = ms_q + 16'd1;
            if (hp_q == HP_MAX) begin
                hp_d    = '0;
                blink_d = ~blink_q;
            end else begin
                hp_d = hp_q + 16'd1;
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_comb begin
        green_d  = green_q;
        yellow_d = yellow_q;
        clear_d  = clear_q;
        if (cmd_valid_i && state_q == S_NOTR) begin
            if (cmd_type_i == CMD_CLEAR)
                clear_d = cmd_data_i;
            // Only in-range directions match, so others are dropped
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (cmd_dir_i == DIR_W'(i)) begin
                    if (cmd_type_i == CMD_GREEN)
                        green_d[i] = cmd_data_i;
                    if (cmd_type_i == CMD_YELLOW)
                        yellow_d[i] = cmd_data_i;
                end
            end
        end
    end

    always_comb begin
        act           = '0;
        act[dir_q]    = 1'b1;
        red_o         = '0;
        yellow_o      = '0;
        green_o       = '0;
        case (state_q)
            S_CLEAR: red_o = '1;
            S_RY: begin
                red_o    = '1;
                yellow_o = act;
            end
            S_G: begin
                red_o   = ~act;
                green_o = act;
            end
            S_GB: begin
                red_o   = ~act;
                green_o = blink_q ? act : '0;
            end
            S_Y: begin
                red_o    = ~act;
                yellow_o = act;
            end
            S_NOTR:  yellow_o = {NUM_DIRS{blink_q}};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= S_CLEAR;
            dir_q   <= '0;
            presc_q <= '0;
            ms_q    <= '0;
            hp_q    <= '0;
            blink_q <= 1'b1;
            clear_q <= 16'(DEFAULT_CLEAR_MS);
            for (int i = 0; i < NUM_DIRS; i++) begin
                green_q[i]  <= 16'(DEFAULT_GREEN_MS);
                yellow_q[i] <= 16'(DEFAULT_YELLOW_MS);
            end
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            hp_q     <= hp_d;
            blink_q  <= blink_d;
            clear_q  <= clear_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
        end
    end

endmodule

// File: tb/tb_traffic_lights_xing.sv
// Segment scoreboard bench for traffic_lights_xing: expected lamp
// segments (lamps, dir, length) are queued and matched as outputs change.
module tb_traffic_lights_xing;

    logic       clk = 1'b0;
    logic       srst;
    logic [2:0] cmd_type;
    logic [1:0] cmd_dir;
    logic       cmd_valid;
    logic [15:0] cmd_data;
    logic [3:0] red, yel, grn;
    logic [1:0] adir;

    traffic_lights_xing dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .cmd_type_i  (cmd_type),
        .cmd_dir_i   (cmd_dir),
        .cmd_valid_i (cmd_valid),
        .cmd_data_i  (cmd_data),
        .red_o       (red),
        .yellow_o    (yel),
        .green_o     (grn),
        .active_dir_o(adir)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    int          restart_req = 0;
    int          restart_ack = 0;
    logic        inv_en = 1'b0;
    logic [13:0] cur = '0;
    logic [13:0] tup;
    int          run = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] seg(input logic [3:0] r,
        input logic [3:0] y, input logic [3:0] g,
        input logic [1:0] d, input int len);
        return {34'd0, r, y, g, d, len[15:0]};
    endfunction

    always @(negedge clk) begin
        tup = {red, yel, grn, adir};
        if (restart_req != restart_ack) begin
            restart_ack = restart_req;
            cur = tup;
            run = 1;
        end else if (tup == cur) begin
            run++;
        end else begin
            if (exp_q.size() > 0)
                chk("seg", {34'd0, cur, run[15:0]}, exp_q.pop_front());
            cur = tup;
            run = 1;
        end
        if (inv_en)
            chk("one_dir", 64'($countones(~red) <= 1), 64'd1);
    end

    task automatic push_dir(input int d, input int clr, input int g);
        logic [3:0] m;
        m = 4'b0001 << d;
        exp_q.push_back(seg(4'hF, 4'h0, 4'h0, 2'(d), clr));
        exp_q.push_back(seg(4'hF, m, 4'h0, 2'(d), 10));
        exp_q.push_back(seg(~m, 4'h0, m, 2'(d), g + 20));
        exp_q.push_back(seg(~m, 4'h0, 4'h0, 2'(d), 20));
        exp_q.push_back(seg(~m, 4'h0, m, 2'(d), 20));
        exp_q.push_back(seg(~m, 4'h0, 4'h0, 2'(d), 20));
        exp_q.push_back(seg(~m, m, 4'h0, 2'(d), 20));
    endtask

    task automatic send(input logic [2:0] t, input logic [1:0] d,
                        input logic [15:0] data);
        cmd_type  = t;
        cmd_dir   = d;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_lamp(input string tag, input bit is_yel,
                             input int idx, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (is_yel ? yel[idx] : grn[idx]) begin
                hit = 1'b1;
                break;
            end
        end
        chk(tag, 64'(hit), 64'd1);
    endtask

    initial begin
        srst      = 1'b1;
        cmd_type  = 3'd0;
        cmd_dir   = 2'd0;
        cmd_valid = 1'b0;
        cmd_data  = 16'd0;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        restart_req++;
        chk("rst_red", 64'(red), 64'hF);
        chk("rst_yel", 64'(yel), 64'h0);
        chk("rst_grn", 64'(grn), 64'h0);
        chk("rst_dir", 64'(adir), 64'h0);

        inv_en = 1'b1;
        for (int d = 0; d < 4; d++) push_dir(d, 4, 20);
        exp_q.push_back(seg(4'hF, 4'h0, 4'h0, 2'd0, 4));
        drain("drain_rr", 700);
        inv_en = 1'b0;

        send(3'd2, 2'd0, 16'd0);
        restart_req++;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(seg(4'h0, 4'hF, 4'h0, 2'd0, 20));
            exp_q.push_back(seg(4'h0, 4'h0, 4'h0, 2'd0, 20));
        end
        drain("drain_notr", 200);

        send(3'd3, 2'd2, 16'd3);
        send(3'd4, 2'd0, 16'd0);
        send(3'd6, 2'd1, 16'd1);
        send(3'd0, 2'd0, 16'd0);
        restart_req++;
        push_dir(0, 2, 20);
        push_dir(1, 2, 20);
        push_dir(2, 2, 6);
        exp_q.push_back(seg(4'hF, 4'h0, 4'h0, 2'd3, 2));
        drain("drain_set", 600);

        exp_q.push_back(seg(4'hF, 4'h8, 4'h0, 2'd3, 10));
        exp_q.push_back(seg(4'h7, 4'h0, 4'h8, 2'd3, 40));
        exp_q.push_back(seg(4'h7, 4'h0, 4'h0, 2'd3, 20));
        exp_q.push_back(seg(4'h7, 4'h0, 4'h8, 2'd3, 20));
        exp_q.push_back(seg(4'h7, 4'h0, 4'h0, 2'd3, 20));
        exp_q.push_back(seg(4'h7, 4'h8, 4'h0, 2'd3, 20));
        exp_q.push_back(seg(4'hF, 4'h0, 4'h0, 2'd0, 2));
        exp_q.push_back(seg(4'hF, 4'h1, 4'h0, 2'd0, 10));
        exp_q.push_back(seg(4'hE, 4'h0, 4'h1, 2'd0, 40));
        wait_lamp("wait_g3", 1'b0, 3, 100);
        send(3'd3, 2'd0, 16'd1);
        wait_lamp("wait_y3", 1'b1, 3, 200);
        send(3'd0, 2'd0, 16'd0);
        drain("drain_ign", 300);

        exp_q.push_back(seg(4'hE, 4'h0, 4'h0, 2'd0, 20));
        exp_q.push_back(seg(4'hE, 4'h0, 4'h1, 2'd0, 20));
        exp_q.push_back(seg(4'hE, 4'h0, 4'h0, 2'd0, 20));
        exp_q.push_back(seg(4'hE, 4'h1, 4'h0, 2'd0, 20));
        wait_lamp("wait_y0", 1'b1, 0, 200);
        repeat (19) @(posedge clk);
        #1 send(3'd1, 2'd0, 16'd0);
        chk("off_lamps", 64'({red, yel, grn}), 64'h0);
        chk("off_dir", 64'(adir), 64'h0);
        drain("drain_off", 10);
        send(3'd2, 2'd0, 16'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("off_notr_ign", 64'({red, yel, grn}), 64'h0);

        send(3'd0, 2'd0, 16'd0);
        wait_lamp("wait_g1", 1'b0, 1, 400);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        srst = 1'b1;
        @(posedge clk);
        #1 srst = 1'b0;
        restart_req++;
        chk("mid_rst_red", 64'(red), 64'hF);
        chk("mid_rst_yg", 64'({yel, grn}), 64'h0);
        chk("mid_rst_dir", 64'(adir), 64'h0);
        exp_q.push_back(seg(4'hF, 4'h0, 4'h0, 2'd0, 4));
        exp_q.push_back(seg(4'hF, 4'h1, 4'h0, 2'd0, 10));
        exp_q.push_back(seg(4'hE, 4'h0, 4'h1, 2'd0, 40));
        drain("drain_rst", 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_lights_xing.md
Name: traffic_lights_xing

Overview:
- Parametrised successor to the single-head traffic light controller: drives NUM_DIRS signal heads at one intersection and serves them round-robin.
- Adds per-direction green/yellow times, an all-red clearance interval between directions, and millisecond-accurate timing via an internal prescaler.
- Sits behind the same 3-bit command interface, extended with a direction select; outputs drive lamp drivers directly.

Parameters:
- NUM_DIRS, 4, number of signal heads (directions); legal range 2..16.
- CLK_PER_MS, 2, clock cycles per millisecond; legal range ≥1.
- BLINK_HALF_PERIOD_MS, 10, blink half period in ms (green blink and yellow service blink).
- BLINK_GREEN_TIME_TICK, 2, number of full blink periods in the green-blink phase.
- RED_YELLOW_MS, 5, red+yellow phase length in ms.
- DEFAULT_GREEN_MS, 10, reset value of every direction's green time.
- DEFAULT_YELLOW_MS, 10, reset value of every direction's yellow time.
- DEFAULT_CLEAR_MS, 2, reset value of the all-red clearance time.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- srst_i  in  1  synchronous active-high reset.
- cmd_type_i  in  3  0 ON, 1 OFF, 2 TO_NOTRANSITION, 3 GREEN_SET, 4 CLEAR_SET, 5 YELLOW_SET; 6 and 7 are ignored.
- cmd_dir_i  in  DIR_W  target direction for GREEN_SET and YELLOW_SET; DIR_W = max(1, clog2(NUM_DIRS)).
- cmd_valid_i  in  1  command strobe, sampled every cycle; no backpressure.
- cmd_data_i  in  16  period in ms for SET commands.
- red_o  out  NUM_DIRS  red lamp per direction.
- yellow_o  out  NUM_DIRS  yellow lamp per direction.
- green_o  out  NUM_DIRS  green lamp per direction.
- active_dir_o  out  DIR_W  direction currently served or next to be served.

Behaviour:
- Clock, reset and outputs
  - One clock; reset is synchronous and active-high.
  - Reset values: state CLEAR, active_dir_o 0, all periods at their defaults, prescaler and ms counter 0.
  - Outputs after reset: red_o all ones, yellow_o 0, green_o 0.
  - Reset asserted in any state, including mid-phase, returns the block to exactly these reset values on the next edge.
- Timing
  - Prescaler counts 0..CLK_PER_MS-1 and produces ms_tick when it is at CLK_PER_MS-1.
  - ms counter advances on each ms_tick.
  - A phase of P ms ends when ms_tick fires and the ms counter equals P-1.
  - Both the prescaler and the ms counter clear on every state change, so a phase lasts exactly P*CLK_PER_MS cycles.
  - Stored period 0 is treated as 1 ms.
- States (outputs are combinational from state; "others" means all non-active directions)
  - CLEAR: all red. Lasts clear_ms, then goes to RY.
  - RY: active direction shows red+yellow; others red. Lasts RED_YELLOW_MS, then goes to G.
  - G: active direction shows green; others red. Lasts green_ms[active], then goes to GB.
  - GB: active green blinks, ON for the first half period, then toggles every BLINK_HALF_PERIOD_MS; others red. Lasts 2*BLINK_GREEN_TIME_TICK*BLINK_HALF_PERIOD_MS, then goes to Y.
  - Y: active direction shows yellow; others red. Lasts yellow_ms[active], then goes to CLEAR and active_dir increments, wrapping from NUM_DIRS-1 to 0.
  - NOTRANSITION: red and green off on all directions; yellow blinks on all directions. Yellow is ON for the first half period after entry and toggles every half period, free-running.
  - OFF: all lamps 0; timers held at 0.
- Commands (cmd_valid_i high; evaluated against the current state)
  - A command has priority over timer expiry in the same cycle.
  - OFF: from any state, go to OFF.
  - TO_NOTRANSITION: from any state except OFF, go to NOTRANSITION. It is ignored in OFF.
  - ON: from OFF or NOTRANSITION, go to CLEAR with active_dir = 0. It is ignored in any running state.
  - GREEN_SET / YELLOW_SET: only in NOTRANSITION. Writes cmd_data_i into green_ms or yellow_ms for cmd_dir_i on the next edge. Ignored if cmd_dir_i ≥ NUM_DIRS.
  - CLEAR_SET: only in NOTRANSITION. Writes clear_ms.
  - SET commands in other states, and types 6 and 7, cause no state or register change.
- New period values apply from the next entry into the corresponding phase.
- Counters are 16 bits wide; a 16-bit period times CLK_PER_MS cannot overflow because the prescaler and ms counter are separate.

Test Plan:
- Reset, no commands, defaults, NUM_DIRS=4, CLK_PER_MS=2 → CLEAR for 4 cycles, then dir0 goes RY 10, G 20, GB 80, Y 20, CLEAR 4, then dir1 RY; after dir3, active_dir_o wraps to 0. In every cycle exactly one direction is non-red, or none is.
- GB phase → green_o[dir] is 1 for 20 cycles, then 0 for 20 cycles, repeated twice; the 80-cycle GB length is exact.
- TO_NOTRANSITION, then GREEN_SET dir2 data 3, CLEAR_SET data 0, then ON → CLEAR lasts 2 cycles (0 treated as 1 ms); dir2 G lasts 6 cycles; dir0 G still lasts 20.
- In NOTRANSITION → yellow_o = 4'hF for 20 cycles, then 4'h0 for 20 cycles, repeating; red_o and green_o are 0.
- GREEN_SET during G, ON during Y, TO_NOTRANSITION while in OFF → no state or register change in any case.
- OFF in the same cycle that Y expires → goes to OFF, all lamps 0, active_dir_o unchanged. Reset asserted mid-G → next cycle is CLEAR, active_dir_o 0, red_o all ones.
